frame_sync: RTL and testbench

//  Byte-stream frame aligner on the demap path; sits directly upstream of crc_calc (MAP_MODE=0).

---
 rtl/frame_sync_pkg.sv | 36 +++
 rtl/frame_sync_fas_detector.sv | 29 ++
 rtl/frame_sync.sv | 153 +++++++++++++++
 tb/tb_frame_sync.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_sync_pkg.sv
// Frame geometry, FAS pattern and aligner state encodings shared by the demap path
// (frame_sync, crc_calc, mapper).
package frame_sync_pkg;

    localparam int          NUM_ROWS          = 4;
    localparam int          LAST_COL          = 1040;
    localparam int          PAYLOAD_FIRST_COL = 16;
    localparam int          PAYLOAD_LAST_COL  = 1039;
    localparam int          FAS_LEN           = 6;
    localparam logic [47:0] FAS_PATTERN       = 48'hF6F6F6282828;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PRESYNC = 2'd1,
        SYNC    = 2'd2
    } sync_state_e;

    typedef struct packed {
        logic [1:0]  row;
        logic [10:0] col;
    } frame_pos_t;

    // Advance one byte: column wraps after LAST_COL, row wraps after the last row.
    function automatic frame_pos_t next_pos(input frame_pos_t p);
        frame_pos_t n;
        n = p;
        if (p.col == 11'(LAST_COL)) begin
            n.col = 11'd0;
            n.row = (p.row == 2'(NUM_ROWS - 1)) ? 2'd0 : p.row + 2'd1;
        end else begin
            n.col = p.col + 11'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/frame_sync_fas_detector.sv
// Sliding FAS detector: keeps the last five valid bytes and flags a hit when the
// current byte completes the 6-byte alignment word.
module frame_sync_fas_detector
    import frame_sync_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_data_valid,
    output logic       o_fas_hit
);

    localparam int SR_W = (FAS_LEN - 1) * 8;

    logic [SR_W-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (i_data_valid) sr_d = {sr_q[SR_W-9:0], i_data};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) sr_q <= '0;
        else       sr_q <= sr_d;
    end

    assign o_fas_hit = i_data_valid && ({sr_q, i_data} == FAS_PATTERN);

endmodule

// File: rtl/frame_sync.sv
// Frame aligner: hunts the FAS, confirms it over SYNC_FRAMES frames, then emits whole
// frames with row/column position and FAS flag one cycle after the input byte.
module frame_sync
    import frame_sync_pkg::*;
#(
    parameter int SYNC_FRAMES = 2,
    parameter int LOSS_FRAMES = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_data,
    input  logic        i_data_valid,
    output logic [7:0]  o_frame_data,
    output logic        o_frame_data_valid,
    output logic        o_frame_data_fas,
    output logic [1:0]  o_row_cnt,
    output logic [10:0] o_col_cnt,
    output logic        o_locked,
    output logic        o_lof
);

    localparam logic [2:0] SYNC_N = 3'(SYNC_FRAMES);
    localparam logic [2:0] LOSS_N = 3'(LOSS_FRAMES);

    sync_state_e state_q, state_d;
    frame_pos_t  pos_q, pos_d, opos_q, opos_d;
    logic [2:0]  match_q, match_d, miss_q, miss_d;
    logic        out_en_q, out_en_d;
    logic [7:0]  data_q, data_d;
    logic        vld_q, vld_d, fas_q, fas_d, lof_q, lof_d, locked_q, locked_d;
    logic        fas_hit, at_chk, at_start;
    logic [2:0]  match_inc, miss_inc;

    frame_sync_fas_detector u_fas (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .o_fas_hit    (fas_hit)
    );

    assign at_start  = (pos_q.row == 2'd0) && (pos_q.col == 11'd0);
    assign at_chk    = i_data_valid && (pos_q.row == 2'd0) && (pos_q.col == 11'(FAS_LEN - 1));
    assign match_inc = match_q + 3'd1;
    assign miss_inc  = miss_q + 3'd1;

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        match_d  = match_q;
        miss_d   = miss_q;
        out_en_d = out_en_q;
        lof_d    = 1'b0;
        data_d   = data_q;
        opos_d   = opos_q;
        fas_d    = fas_q;
        vld_d    = 1'b0;
        if (i_data_valid) begin
            case (state_q)
                HUNT: begin
                    if (fas_hit) begin
                        // The hit byte sits at row0 col5, so the next byte is col6.
                        pos_d.row = 2'd0;
                        pos_d.col = 11'(FAS_LEN);
                        match_d   = 3'd1;
                        if (SYNC_N == 3'd1) begin
                            state_d = SYNC;
                            miss_d  = 3'd0;
                        end else begin
                            state_d = PRESYNC;
                        end
                    end
                end
                PRESYNC: begin
                    pos_d = next_pos(pos_q);
                    if (at_chk) begin
                        if (fas_hit) begin
                            match_d = match_inc;
                            if (match_inc == SYNC_N) begin
                                state_d = SYNC;
                                miss_d  = 3'd0;
                            end
                        end else begin
                            state_d = HUNT;
                            match_d = 3'd0;
                        end
                    end
                end
                SYNC: begin
                    pos_d = next_pos(pos_q);
                    if (at_start) out_en_d = 1'b1;
                    if (at_chk) begin
                        if (fas_hit) begin
                            miss_d = 3'd0;
                        end else begin
                            miss_d = miss_inc;
                            if (miss_inc == LOSS_N) begin
                                state_d  = HUNT;
                                match_d  = 3'd0;
                                lof_d    = 1'b1;
                                out_en_d = 1'b0;
                            end
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
            data_d = i_data;
            opos_d = pos_q;
            fas_d  = (pos_q.row == 2'd0) && (pos_q.col <= 11'(FAS_LEN - 1));
            // Still emits the byte that triggers loss; first emitted byte is row0 col0.
            vld_d  = out_en_q || (state_q == SYNC && at_start);
        end
        locked_d = (state_d == SYNC);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= HUNT;
            pos_q    <= '0;
            match_q  <= '0;
            miss_q   <= '0;
            out_en_q <= 1'b0;
            lof_q    <= 1'b0;
            locked_q <= 1'b0;
            data_q   <= '0;
            opos_q   <= '0;
            fas_q    <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            match_q  <= match_d;
            miss_q   <= miss_d;
            out_en_q <= out_en_d;
            lof_q    <= lof_d;
            locked_q <= locked_d;
            data_q   <= data_d;
            opos_q   <= opos_d;
            fas_q    <= fas_d;
            vld_q    <= vld_d;
        end
    end

    assign o_frame_data       = data_q;
    assign o_frame_data_valid = vld_q;
    assign o_frame_data_fas   = fas_q;
    assign o_row_cnt          = opos_q.row;
    assign o_col_cnt          = opos_q.col;
    assign o_locked           = locked_q;
    assign o_lof              = lof_q;

endmodule

// File: tb/tb_frame_sync.sv
// Directed bench for frame_sync: default instance (2/4) plus a 1/1 instance for fast lock/loss.
module tb_frame_sync;

    localparam int FRAME_LEN = 4164;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  data = 8'h00;
    logic        va = 1'b0, vb = 1'b0;
    logic        sel = 1'b0;

    logic [7:0]  a_fd, b_fd;
    logic        a_fv, b_fv, a_ff, b_ff, a_lk, b_lk, a_lof, b_lof;
    logic [1:0]  a_row, b_row;
    logic [10:0] a_col, b_col;

    logic [7:0]  s_data;
    logic        s_vld, s_fas, s_locked, s_lof;
    logic [1:0]  s_row;
    logic [10:0] s_col;

    int total = 0;
    int bad   = 0;

    int vcnt, fcnt, pos_err, idle_err, lofc, locked_seen;
    int first_data, first_row, first_col, last_row, last_col;

    always #5 clk = ~clk;

    frame_sync #(.SYNC_FRAMES(2), .LOSS_FRAMES(4)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_data_valid(va),
        .o_frame_data(a_fd), .o_frame_data_valid(a_fv), .o_frame_data_fas(a_ff),
        .o_row_cnt(a_row), .o_col_cnt(a_col), .o_locked(a_lk), .o_lof(a_lof)
    );

    frame_sync #(.SYNC_FRAMES(1), .LOSS_FRAMES(1)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_data_valid(vb),
        .o_frame_data(b_fd), .o_frame_data_valid(b_fv), .o_frame_data_fas(b_ff),
        .o_row_cnt(b_row), .o_col_cnt(b_col), .o_locked(b_lk), .o_lof(b_lof)
    );

    always_comb begin
        s_data   = sel ? b_fd  : a_fd;
        s_vld    = sel ? b_fv  : a_fv;
        s_fas    = sel ? b_ff  : a_ff;
        s_row    = sel ? b_row : a_row;
        s_col    = sel ? b_col : a_col;
        s_locked = sel ? b_lk  : a_lk;
        s_lof    = sel ? b_lof : a_lof;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [7:0] b, input logic v);
        data = b;
        va   = sel ? 1'b0 : v;
        vb   = sel ? v : 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] frame_byte(input int k, input bit corrupt);
        if (k < 3)  return 8'hF6;
        if (k == 3) return corrupt ? 8'h29 : 8'h28;
        if (k < 6)  return 8'h28;
        return 8'h50 + 8'(k % 7);
    endfunction

    task automatic clear_stats();
        vcnt = 0; fcnt = 0; pos_err = 0; idle_err = 0; lofc = 0; locked_seen = 0;
        first_data = -1; first_row = -1; first_col = -1; last_row = -1; last_col = -1;
    endtask

    // Sends bytes 0..len-1 of a frame aligned to row0 col0; gap inserts idle cycles.
    task automatic send_frame(input int len, input bit corrupt, input bit gap);
        logic [7:0] b;
        int row, col, n, prev_col;
        clear_stats();
        for (int k = 0; k < len; k++) begin
            if (gap && $urandom_range(0, 3) == 0) begin
                n = $urandom_range(1, 3);
                for (int j = 0; j < n; j++) begin
                    prev_col = int'(s_col);
                    step(8'($urandom_range(0, 255)), 1'b0);
                    if (s_vld !== 1'b0 || int'(s_col) != prev_col) idle_err++;
                    if (s_lof) lofc++;
                end
            end
            b = frame_byte(k, corrupt);
            step(b, 1'b1);
            row = k / 1041;
            col = k % 1041;
            if (s_lof) lofc++;
            if (s_locked) locked_seen = 1;
            if (s_vld) begin
                vcnt++;
                if (first_col < 0) begin
                    first_data = int'(s_data); first_row = int'(s_row); first_col = int'(s_col);
                end
                if (s_data !== b || int'(s_row) != row || int'(s_col) != col ||
                    s_fas !== (row == 0 && col < 6)) pos_err++;
                if (s_fas) fcnt++;
                last_row = int'(s_row);
                last_col = int'(s_col);
            end
        end
    endtask

    task automatic send_filler(input int len);
        clear_stats();
        for (int k = 0; k < len; k++) begin
            step(8'h50 + 8'(k % 7), 1'b1);
            if (s_vld) vcnt++;
            if (s_locked) locked_seen = 1;
            if (s_lof) lofc++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lof_sum;
        // Reset state
        rst = 1'b1;
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);
        chk("rst_data",   int'(a_fd), 0);
        chk("rst_valid",  int'(a_fv), 0);
        chk("rst_fas",    int'(a_ff), 0);
        chk("rst_row",    int'(a_row), 0);
        chk("rst_col",    int'(a_col), 0);
        chk("rst_locked", int'(a_lk), 0);
        chk("rst_lof",    int'(a_lof), 0);
        chk("rst_b_locked", int'(b_lk), 0);
        rst = 1'b0;

        // Unaligned prefix then three clean frames
        for (int i = 0; i < 37; i++) step(8'($urandom_range(0, 39)), 1'b1);
        send_frame(FRAME_LEN, 1'b0, 1'b0);
        chk("s1_f1_state", int'(dut_a.state_q), 1);
        chk("s1_f1_locked", int'(a_lk), 0);
        chk("s1_f1_vcnt", vcnt, 0);
        send_frame(FRAME_LEN, 1'b0, 1'b0);
        chk("s1_f2_locked", int'(a_lk), 1);
        chk("s1_f2_vcnt", vcnt, 0);
        send_frame(FRAME_LEN, 1'b0, 1'b0);
        chk("s1_f3_vcnt", vcnt, FRAME_LEN);
        chk("s1_f3_first_data", first_data, 246);
        chk("s1_f3_first_row", first_row, 0);
        chk("s1_f3_first_col", first_col, 0);
        chk("s1_f3_fas_cnt", fcnt, 6);
        chk("s1_f3_pos_err", pos_err, 0);

        // Three misses then a clean frame: stays locked
        lof_sum = 0;
        for (int f = 0; f < 3; f++) begin
            send_frame(FRAME_LEN, 1'b1, 1'b0);
            chk("s2_bad_vcnt", vcnt, FRAME_LEN);
            lof_sum += lofc;
        end
        chk("s2_miss3", int'(dut_a.miss_q), 3);
        send_frame(FRAME_LEN, 1'b0, 1'b0);
        lof_sum += lofc;
        chk("s2_miss_clear", int'(dut_a.miss_q), 0);
        chk("s2_still_locked", int'(a_lk), 1);
        chk("s2_no_lof", lof_sum, 0);
        // Four misses: loss of frame
        for (int f = 0; f < 3; f++) begin
            send_frame(FRAME_LEN, 1'b1, 1'b0);
            lof_sum += lofc;
        end
        chk("s2_locked_before_loss", int'(a_lk), 1);
        send_frame(10, 1'b1, 1'b0);
        chk("s2_lof_pulses", lof_sum + lofc, 1);
        chk("s2_loss_vcnt", vcnt, 6);
        chk("s2_unlocked", int'(a_lk), 0);
        chk("s2_valid_low", int'(a_fv), 0);

        // False FAS in payload while hunting
        send_filler(100);
        for (int k = 0; k < 6; k++) step(frame_byte(k, 1'b0), 1'b1);
        chk("s3_presync", int'(dut_a.state_q), 1);
        send_filler(FRAME_LEN + 6);
        chk("s3_back_hunt", int'(dut_a.state_q), 0);
        chk("s3_never_locked", locked_seen, 0);
        chk("s3_no_valid", vcnt, 0);

        // Relock, then a frame with random valid gaps
        send_frame(FRAME_LEN, 1'b0, 1'b0);
        send_frame(FRAME_LEN, 1'b0, 1'b0);
        chk("s4_locked", int'(a_lk), 1);
        send_frame(FRAME_LEN, 1'b0, 1'b1);
        chk("s4_vcnt", vcnt, FRAME_LEN);
        chk("s4_pos_err", pos_err, 0);
        chk("s4_idle_err", idle_err, 0);
        chk("s4_fas_cnt", fcnt, 6);
        chk("s4_last_row", last_row, 3);
        chk("s4_last_col", last_col, 1040);

        // Reset at row2 col500 while locked
        send_frame(2 * 1041 + 500, 1'b0, 1'b0);
        chk("s5_pre_rst_col", int'(a_col), 499);
        rst = 1'b1;
        step(8'hAA, 1'b1);
        chk("s5_rst_data",   int'(a_fd), 0);
        chk("s5_rst_valid",  int'(a_fv), 0);
        chk("s5_rst_row",    int'(a_row), 0);
        chk("s5_rst_col",    int'(a_col), 0);
        chk("s5_rst_locked", int'(a_lk), 0);
        chk("s5_rst_state",  int'(dut_a.state_q), 0);
        rst = 1'b0;
        send_frame(FRAME_LEN, 1'b0, 1'b0);
        chk("s5_presync", int'(dut_a.state_q), 1);
        send_frame(10, 1'b0, 1'b0);
        chk("s5_relocked", int'(a_lk), 1);
        chk("s5_relock_vcnt", vcnt, 0);

        // SYNC_FRAMES=1, LOSS_FRAMES=1 instance
        sel = 1'b1;
        for (int k = 0; k < 6; k++) step(frame_byte(k, 1'b0), 1'b1);
        chk("s6_lock_first_fas", int'(b_lk), 1);
        send_filler(FRAME_LEN - 6);
        chk("s6_no_early_valid", vcnt, 0);
        send_frame(10, 1'b1, 1'b0);
        chk("s6_lof", lofc, 1);
        chk("s6_vcnt", vcnt, 6);
        chk("s6_unlocked", int'(b_lk), 0);
        sel = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
